// File: rtl/ara_apb_uart_tx.sv
`timescale 1ns/1ps
// ara_apb_uart_tx: transmit-only UART with an APB3 slave port.
// CPU-written bytes are buffered in a FIFO and sent as 8N1 frames on tx_o.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   psel_i, penable_i, pwrite_i   APB control (access = psel_i & penable_i)
//   paddr_i, pwdata_i             APB address (bits [11:0] decoded) / write data
//   prdata_o, pready_o, pslverr_o APB response (zero wait states)
//   tx_o                          serial output, idle high
//   irq_o                         level interrupt: FIFO empty and transmitter idle
//
// Register map: 0x000 THR (wo), 0x004 STATUS (ro), 0x008 DIV (rw, 16 bit)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for bit_div cycles
// S_DATA  | 8 data bits, LSB first, bit_div cycles each
// S_STOP  | stop bit (high); pops the next byte directly
module ara_apb_uart_tx #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned FifoDepth = 16,
    parameter logic [15:0] DivReset  = 16'd868
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 tx_o,
    output logic                 irq_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam logic [PtrW:0] PtrOne = 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [15:0]   r_baud_cnt, w_baud_nxt;
    logic [15:0]   r_bit_div, w_bit_div_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_irq;
    logic [15:0]   r_div;

    logic [7:0]    r_mem [FifoDepth];
    logic [PtrW:0] r_wptr, r_rptr;
    logic [PtrW:0] w_level;
    logic [8:0]    w_level9;
    logic [7:0]    w_level_sat;
    logic          w_empty, w_full, w_push, w_pop, w_div_we, w_baud_tc;
    logic          w_access;
    logic [11:0]   w_addr;
    logic [15:0]   w_div_eff;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_access = psel_i & penable_i;
    assign w_addr   = paddr_i[11:0];
    assign w_unused = ^{paddr_i, pwdata_i[31:16]};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level  = r_wptr - r_rptr;
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                      (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
    // The status field is 8 bits wide; a 256-deep full FIFO reads as 0xFF.
    assign w_level9    = 9'(w_level);
    assign w_level_sat = w_level9[8] ? 8'hFF : w_level9[7:0];
    assign w_status    = {16'h0, w_level_sat, 5'h0, (r_state != S_IDLE), w_full, w_empty};

    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_baud_tc = (r_baud_cnt == r_bit_div - 16'd1);

    // A THR write into a full FIFO is still accepted when the transmitter
    // pops in the same cycle.
    always_comb begin
        prdata_o  = 32'h0;
        pslverr_o = 1'b0;
        w_push    = 1'b0;
        w_div_we  = 1'b0;
        if (w_access) begin
            case (w_addr)
                12'h000: begin
                    if (!pwrite_i)            pslverr_o = 1'b1;
                    else if (w_full && !w_pop) pslverr_o = 1'b1;
                    else                      w_push    = 1'b1;
                end
                12'h004: begin
                    if (pwrite_i) pslverr_o = 1'b1;
                    else          prdata_o  = w_status;
                end
                12'h008: begin
                    if (pwrite_i) w_div_we = 1'b1;
                    else          prdata_o = {16'h0, r_div};
                end
                default: pslverr_o = 1'b1;
            endcase
        end
    end

    assign pready_o = 1'b1;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[PtrW-1:0]] <= pwdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_div  <= DivReset;
        end else begin
            if (w_push)   r_wptr <= r_wptr + PtrOne;
            if (w_pop)    r_rptr <= r_rptr + PtrOne;
            if (w_div_we) r_div  <= pwdata_i[15:0];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_baud_nxt    = r_baud_cnt;
        w_bit_div_nxt = r_bit_div;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_pop = 1'b1;
            end
            S_START: begin
                if (w_baud_tc) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_tc) begin
                    w_baud_nxt    = 16'd0;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_tc) begin
                    w_baud_nxt = 16'd0;
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud_cnt + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // bit_div is captured here so DIV writes only affect later frames.
        if (w_pop) begin
            w_state_nxt   = S_START;
            w_shift_nxt   = r_mem[r_rptr[PtrW-1:0]];
            w_bit_div_nxt = w_div_eff;
            w_bit_cnt_nxt = 3'd0;
            w_baud_nxt    = 16'd0;
        end
        // tx_o is registered from the next state so the line never glitches.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h0;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_bit_div  <= 16'd1;
            r_tx       <= 1'b1;
            r_irq      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_div  <= w_bit_div_nxt;
            r_tx       <= w_tx_nxt;
            r_irq      <= w_empty && (r_state == S_IDLE);
        end
    end

    assign tx_o  = r_tx;
    assign irq_o = r_irq;

endmodule

// File: tb/tb_ara_apb_uart_tx.sv
`timescale 1ns/1ps
module tb_ara_apb_uart_tx;

    logic        clk, rst_n, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr, tx, irq;

    ara_apb_uart_tx dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .tx_o      (tx),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] div;
        logic        b2b;
        logic        partial;
    } tx_exp_t;

    logic [32:0] apb_q[$];
    string       apb_name_q[$];
    tx_exp_t     tx_q[$];
    bit          mon_busy = 1'b0;
    int          gap = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Caller is positioned just after a rising edge; returns likewise.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_rdata, input logic exp_err, input string name);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable  = 1'b1;
        last_acc = cyc;
        apb_q.push_back({exp_err, exp_rdata});
        apb_name_q.push_back(name);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, input logic err, input string name);
        apb_xfer(1'b1, addr, data, 32'h0, err, name);
    endtask

    task automatic apb_rd(input logic [31:0] addr, input logic [31:0] exp, input logic err, input string name);
        apb_xfer(1'b0, addr, 32'h0, exp, err, name);
    endtask

    task automatic wait_tx_done(input int budget, input string name);
        int n = 0;
        while ((tx_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n >= budget), 32'd0);
        @(posedge clk); #1;
    endtask

    // APB response monitor
    always @(negedge clk) begin
        logic [32:0] e;
        string       nm;
        if (rst_n && psel && penable) begin
            if (apb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL apb_unexpected: access with nothing expected at t=%0t", $time);
            end else begin
                e  = apb_q.pop_front();
                nm = apb_name_q.pop_front();
                chk({nm, "_rdata"},   prdata,             e[31:0]);
                chk({nm, "_pslverr"}, {31'h0, pslverr},   {31'h0, e[32]});
                chk({nm, "_pready"},  {31'h0, pready},    32'd1);
            end
        end
    end

    // Serial line monitor: on a start bit, pop the expected byte and check every cycle
    initial begin
        tx_exp_t    e;
        int         errs, d;
        bit         aborted;
        logic [9:0] frame;
        forever begin
            @(negedge clk);
            if (!rst_n) begin gap = 0; continue; end
            if (tx !== 1'b0) begin gap++; continue; end
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected_frame: tx_o low at cycle %0d with no byte queued", cyc);
                repeat (10) @(negedge clk);
                gap = 0;
                continue;
            end
            e        = tx_q.pop_front();
            mon_busy = 1'b1;
            if (e.b2b) chk($sformatf("tx_gap_before_%02h", e.data), gap, 0);
            frame   = {1'b1, e.data, 1'b0};
            d       = int'(e.div);
            errs    = 0;
            aborted = 1'b0;
            for (int i = 0; i < 10 * d; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    if (!rst_n) begin aborted = 1'b1; break; end
                end
                if (tx !== frame[i / d]) errs++;
            end
            chk($sformatf("tx_frame_%02h_bit_errors", e.data), errs, 0);
            chk($sformatf("tx_frame_%02h_reset_abort", e.data), {31'h0, aborted}, {31'h0, e.partial});
            gap      = 0;
            mon_busy = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a_cyc;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",      {31'h0, tx},      32'd1);
        chk("rst_irq",     {31'h0, irq},     32'd1);
        chk("rst_pready",  {31'h0, pready},  32'd1);
        chk("rst_prdata",  prdata,           32'd0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_rd(32'h004, 32'h0000_0001, 1'b0, "rst_status");
        apb_rd(32'h008, 32'h0000_0364, 1'b0, "rst_div");

        // DIV=4, single byte 0xA5 with latency and irq timing
        apb_wr(32'h008, 32'd4, 1'b0, "div4");
        apb_rd(32'h008, 32'd4, 1'b0, "div4_rb");
        tx_q.push_back('{8'hA5, 16'd4, 1'b0, 1'b0});
        apb_wr(32'h000, 32'hFFFF_FFA5, 1'b0, "thr_a5");
        @(negedge clk); chk("lat_c1_tx", {31'h0, tx}, 32'd1);
        @(negedge clk); chk("lat_c2_tx", {31'h0, tx}, 32'd0);
        chk("lat_c2_irq", {31'h0, irq}, 32'd0);
        repeat (39) @(negedge clk);
        chk("stop_irq", {31'h0, irq}, 32'd0);
        @(negedge clk); chk("idle_irq_lag", {31'h0, irq}, 32'd0);
        @(negedge clk); chk("irq_rise", {31'h0, irq}, 32'd1);
        @(posedge clk); #1;
        apb_rd(32'h004, 32'h0000_0001, 1'b0, "idle_status");

        // Bad offsets and illegal access directions
        apb_rd(32'h00C, 32'h0, 1'b1, "rd_00c");
        apb_wr(32'h00C, 32'hFFFF, 1'b1, "wr_00c");
        apb_rd(32'hFFC, 32'h0, 1'b1, "rd_ffc");
        apb_wr(32'hFFC, 32'h1234, 1'b1, "wr_ffc");
        apb_wr(32'h004, 32'hFFFF_FFFF, 1'b1, "wr_status");
        apb_rd(32'h000, 32'h0, 1'b1, "rd_thr");
        apb_rd(32'h008, 32'd4, 1'b0, "div_unchanged");
        apb_rd(32'h004, 32'h0000_0001, 1'b0, "status_unchanged");
        apb_rd(32'h0000_1008, 32'd4, 1'b0, "div_alias");

        // Fill the FIFO behind a slow frame, overflow, then push on the pop cycle
        apb_wr(32'h008, 32'd100, 1'b0, "div100");
        tx_q.push_back('{8'h11, 16'd100, 1'b0, 1'b0});
        apb_wr(32'h000, 32'h11, 1'b0, "thr_11");
        a_cyc = last_acc;
        apb_wr(32'h008, 32'd1, 1'b0, "div1");
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back('{8'(8'h20 + i), 16'd1, 1'b1, 1'b0});
            apb_wr(32'h000, 32'(8'h20 + i), 1'b0, "thr_fill");
        end
        apb_rd(32'h004, 32'h0000_1006, 1'b0, "status_full");
        apb_wr(32'h000, 32'h5A, 1'b1, "thr_overflow");
        apb_rd(32'h004, 32'h0000_1006, 1'b0, "status_full2");
        while (cyc < a_cyc + 1000) begin @(posedge clk); #1; end
        tx_q.push_back('{8'h77, 16'd1, 1'b1, 1'b0});
        apb_wr(32'h000, 32'h77, 1'b0, "thr_push_on_pop");
        apb_rd(32'h004, 32'h0000_1006, 1'b0, "status_after_pop_push");
        wait_tx_done(2000, "burst");

        // DIV change mid-frame only affects the next frame
        apb_wr(32'h008, 32'd2, 1'b0, "div2");
        tx_q.push_back('{8'hFF, 16'd2, 1'b0, 1'b0});
        apb_wr(32'h000, 32'hFF, 1'b0, "thr_ff");
        repeat (3) @(posedge clk); #1;
        apb_wr(32'h008, 32'd8, 1'b0, "div8_mid");
        tx_q.push_back('{8'h3C, 16'd8, 1'b1, 1'b0});
        apb_wr(32'h000, 32'h3C, 1'b0, "thr_3c");
        apb_rd(32'h008, 32'd8, 1'b0, "div8_rb");
        wait_tx_done(500, "divchg");

        // DIV=0 behaves as 1
        apb_wr(32'h008, 32'd0, 1'b0, "div0");
        apb_rd(32'h008, 32'd0, 1'b0, "div0_rb");
        tx_q.push_back('{8'h96, 16'd1, 1'b0, 1'b0});
        apb_wr(32'h000, 32'h96, 1'b0, "thr_96");
        wait_tx_done(200, "div0");

        // Reset in the middle of the data bits of 0x00
        apb_wr(32'h008, 32'd4, 1'b0, "div4b");
        tx_q.push_back('{8'h00, 16'd4, 1'b0, 1'b1});
        apb_wr(32'h000, 32'h00, 1'b0, "thr_00");
        apb_wr(32'h000, 32'h55, 1'b0, "thr_55_lost");
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_tx", {31'h0, tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx",  {31'h0, tx},  32'd1);
        chk("rst_async_irq", {31'h0, irq}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_rd(32'h004, 32'h0000_0001, 1'b0, "post_rst_status");
        repeat (200) @(posedge clk);
        #1;
        chk("tx_q_empty",    tx_q.size(),  32'd0);
        chk("apb_q_empty",   apb_q.size(), 32'd0);
        chk("final_tx_idle", {31'h0, tx},  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
